// File: rtl/teclado_scanner_pkg.sv
// Key-code constants and the row/column lookup shared by the keypad scanner
// and the calculator that consumes its key stream.
package TECLAS;

   localparam logic [4:0] T_A    = 5'd10;
   localparam logic [4:0] T_B    = 5'd11;
   localparam logic [4:0] T_C    = 5'd12;
   localparam logic [4:0] T_D    = 5'd13;
   localparam logic [4:0] T_ASTE = 5'd14;
   localparam logic [4:0] T_HASH = 5'd15;
   localparam logic [4:0] T_NONE = 5'd31;

   typedef enum logic [1:0] {
      RES_NONE  = 2'd0,
      RES_KEY   = 2'd1,
      RES_MULTI = 2'd2
   } res_kind_e;

   // Code is normalised to T_NONE unless kind is RES_KEY, so whole-struct compares work.
   typedef struct packed {
      res_kind_e  kind;
      logic [4:0] code;
   } frame_res_t;

   function automatic logic [4:0] key_code(input logic [1:0] row, input logic [1:0] col);
      logic [4:0] code;
      case ({row, col})
         4'd0:    code = 5'd1;
         4'd1:    code = 5'd2;
         4'd2:    code = 5'd3;
         4'd3:    code = T_A;
         4'd4:    code = 5'd4;
         4'd5:    code = 5'd5;
         4'd6:    code = 5'd6;
         4'd7:    code = T_B;
         4'd8:    code = 5'd7;
         4'd9:    code = 5'd8;
         4'd10:   code = 5'd9;
         4'd11:   code = T_C;
         4'd12:   code = T_ASTE;
         4'd13:   code = 5'd0;
         4'd14:   code = T_HASH;
         4'd15:   code = T_D;
         default: code = T_NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/teclado_scanner_if.sv
// Keypad-side and key-stream signals of the scanner; slave is the scanner itself.
interface teclado_scanner_if;
   logic [3:0] linhas;
   logic [3:0] colunas;
   logic [4:0] tecla_atual;
   logic       ativo;

   modport master (output linhas, input colunas, input tecla_atual, input ativo);
   modport slave  (input linhas, output colunas, output tecla_atual, output ativo);
endinterface

// File: rtl/teclado_scanner_debounce_frames.sv
// Frame-level debounce: counts identical consecutive frame results and emits one
// press strobe per NONE->KEY transition of the accepted state.
module debounce_frames
   import TECLAS::*;
#(
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_frame_done,
   input  frame_res_t i_res,
   output logic       o_ativo,
   output logic [4:0] o_tecla
);

   localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

   frame_res_t      r_prev;
   logic [CW-1:0]   r_cnt;
   res_kind_e       r_acc;
   logic            r_ativo;
   logic [4:0]      r_tecla;

   frame_res_t      w_prev_n;
   logic [CW-1:0]   w_cnt_n;
   res_kind_e       w_acc_n;
   logic            w_pulse;
   logic [4:0]      w_tecla_n;

   // Next-state: stability counting, then acceptance against the accepted state.
   always_comb begin
      w_prev_n  = r_prev;
      w_cnt_n   = r_cnt;
      w_acc_n   = r_acc;
      w_pulse   = 1'b0;
      w_tecla_n = r_tecla;
      if (i_frame_done) begin
         if (i_res == r_prev) begin
            if (r_cnt < CW'(DEBOUNCE_FRAMES)) begin
               w_cnt_n = r_cnt + CW'(1);
            end else begin
               w_cnt_n = r_cnt;
            end
         end else begin
            w_cnt_n  = CW'(1);
            w_prev_n = i_res;
         end
         if (w_cnt_n == CW'(DEBOUNCE_FRAMES)) begin
            case (w_prev_n.kind)
               RES_KEY: begin
                  // A different key or a chord held before needs a release first.
                  if (r_acc == RES_NONE) begin
                     w_acc_n   = RES_KEY;
                     w_pulse   = 1'b1;
                     w_tecla_n = w_prev_n.code;
                  end else begin
                     w_acc_n = r_acc;
                  end
               end
               RES_NONE:  w_acc_n = RES_NONE;
               RES_MULTI: w_acc_n = RES_MULTI;
               default:   w_acc_n = r_acc;
            endcase
         end else begin
            w_acc_n = r_acc;
         end
      end else begin
         w_pulse = 1'b0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev  <= '{kind: RES_NONE, code: T_NONE};
         r_cnt   <= '0;
         r_acc   <= RES_NONE;
         r_ativo <= 1'b0;
         r_tecla <= T_NONE;
      end else begin
         r_prev  <= w_prev_n;
         r_cnt   <= w_cnt_n;
         r_acc   <= w_acc_n;
         r_ativo <= w_pulse;
         r_tecla <= w_tecla_n;
      end
   end

   assign o_ativo = r_ativo;
   assign o_tecla = r_tecla;

endmodule

// File: rtl/teclado_scanner.sv
// 4x4 keypad scanner: row synchroniser, column scan, per-frame row accumulation
// and frame-level debounce producing the tecla_atual/ativo key stream.
module teclado_scanner
   import TECLAS::*;
#(
   parameter int SCAN_DIV        = 16,
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   teclado_scanner_if.slave   kp
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [SW-1:0] r_slot;
   logic [1:0]    r_col;
   logic [3:0]    r_colunas;
   logic [1:0]    r_acc_cnt;
   logic [4:0]    r_acc_code;

   logic          w_sample;
   logic          w_frame_done;
   logic [1:0]    w_cnt;
   logic [4:0]    w_code;
   frame_res_t    w_res;

   assign w_sample     = (r_slot == SW'(SCAN_DIV - 1));
   assign w_frame_done = w_sample && (r_col == 2'd3);

   // Merge this column's low rows into the running frame (count saturates at 2 = chord).
   always_comb begin
      w_cnt  = r_acc_cnt;
      w_code = r_acc_code;
      for (int r = 0; r < 4; r++) begin
         if (!r_sync2[r]) begin
            if (w_cnt == 2'd0) begin
               w_code = key_code(2'(r), r_col);
            end else begin
               w_code = w_code;
            end
            if (w_cnt != 2'd2) begin
               w_cnt = w_cnt + 2'd1;
            end else begin
               w_cnt = w_cnt;
            end
         end else begin
            w_cnt = w_cnt;
         end
      end
   end

   // Classify the completed frame.
   always_comb begin
      w_res = '{kind: RES_NONE, code: T_NONE};
      case (w_cnt)
         2'd0:    w_res = '{kind: RES_NONE,  code: T_NONE};
         2'd1:    w_res = '{kind: RES_KEY,   code: w_code};
         default: w_res = '{kind: RES_MULTI, code: T_NONE};
      endcase
   end

   // Row synchroniser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 4'b1111;
         r_sync2 <= 4'b1111;
      end else begin
         r_sync1 <= kp.linhas;
         r_sync2 <= r_sync1;
      end
   end

   // Slot counter and column shifter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot    <= '0;
         r_col     <= 2'd0;
         r_colunas <= 4'b1110;
      end else if (w_sample) begin
         r_slot    <= '0;
         r_col     <= r_col + 2'd1;
         r_colunas <= {r_colunas[2:0], r_colunas[3]};
      end else begin
         r_slot    <= r_slot + SW'(1);
      end
   end

   // Frame accumulator, cleared after the c3 sample hands the frame to debounce.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc_cnt  <= 2'd0;
         r_acc_code <= T_NONE;
      end else if (w_frame_done) begin
         r_acc_cnt  <= 2'd0;
         r_acc_code <= T_NONE;
      end else if (w_sample) begin
         r_acc_cnt  <= w_cnt;
         r_acc_code <= w_code;
      end else begin
         r_acc_cnt  <= r_acc_cnt;
      end
   end

   debounce_frames #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_debounce (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_frame_done (w_frame_done),
      .i_res        (w_res),
      .o_ativo      (kp.ativo),
      .o_tecla      (kp.tecla_atual)
   );

   assign kp.colunas = r_colunas;

endmodule
